golomb_job_scheduler: RTL and testbench

Sequencer between the host link and one `mark_counter_assembly` search engine. It accepts search jobs (a preset ruler prefix plus the first variable position) over a valid/ready handshake and restarts the assembly for each job. It waits for completion, then drains the assembly's result list into a global best-ruler table that persists across jobs, so that a search split across many prefixes yields one merged optimum.

---
 rtl/golomb_pkg.sv | 19 +
 rtl/golomb_result_merge.sv | 90 +++++++++
 rtl/golomb_job_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_golomb_job_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/golomb_pkg.sv
// Shared widths, sentinel length and scheduler state encoding for the
// Golomb ruler job scheduler.
package golomb_pkg;

  localparam int MARK_W = 9;
  localparam int POS_W  = 7;
  localparam int CNT_W  = 6;

  localparam logic [MARK_W-1:0] NO_LENGTH = 9'h1FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASM_RST,
    S_RUN,
    S_COLLECT,
    S_FINISH
  } sched_state_t;

endpackage

// File: rtl/golomb_result_merge.sv
// Global best-ruler table: merges one candidate ruler per cycle, counts
// equal-length rulers lost to a full table, and serves a registered read port.
module golomb_result_merge
  import golomb_pkg::*;
#(
  parameter  int NUMPOSITIONS = 5,
  parameter  int NUMRESULTS   = 10,
  localparam int W            = (NUMPOSITIONS + 1) * MARK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [W-1:0]      in_ruler,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [MARK_W-1:0] best_len,
  output logic [CNT_W-1:0]  best_count,
  output logic [7:0]        drop_count,
  output logic [W-1:0]      rd_ruler
);

  logic [W-1:0]      table_q [NUMRESULTS];
  logic [W-1:0]      table_d [NUMRESULTS];
  logic [MARK_W-1:0] best_len_q, best_len_d;
  logic [CNT_W-1:0]  best_count_q, best_count_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic [W-1:0]      rd_ruler_q, rd_ruler_d;
  logic [MARK_W-1:0] in_len;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    table_d      = table_q;
    best_len_d   = best_len_q;
    best_count_d = best_count_q;
    drop_count_d = drop_count_q;
    rd_ruler_d   = '0;
    in_len       = in_ruler[MARK_W-1:0];

    if (clear) begin
      best_len_d   = NO_LENGTH;
      best_count_d = '0;
    end else if (in_valid && in_len != '0) begin
      if (in_len < best_len_q) begin
        table_d[0]   = in_ruler;
        best_len_d   = in_len;
        best_count_d = CNT_W'(1);
      end else if (in_len == best_len_q) begin
        if (best_count_q < CNT_W'(NUMRESULTS)) begin
          for (int i = 0; i < NUMRESULTS; i++) begin
            if (CNT_W'(i) == best_count_q) table_d[i] = in_ruler;
          end
          best_count_d = best_count_q + CNT_W'(1);
        end else if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
    end

    // Entries at or beyond best_count are stale and must read as zero.
    for (int i = 0; i < NUMRESULTS; i++) begin
      if (CNT_W'(i) == rd_idx && rd_idx < best_count_q) rd_ruler_d = table_q[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      best_len_q   <= NO_LENGTH;
      best_count_q <= '0;
      drop_count_q <= '0;
      rd_ruler_q   <= '0;
    end else begin
      best_len_q   <= best_len_d;
      best_count_q <= best_count_d;
      drop_count_q <= drop_count_d;
      rd_ruler_q   <= rd_ruler_d;
    end
  end

  // NOTE: the table storage is not reset; best_count gates every read of it.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  assign best_len   = best_len_q;
  assign best_count = best_count_q;
  assign drop_count = drop_count_q;
  assign rd_ruler   = rd_ruler_q;

endmodule

// File: rtl/golomb_job_scheduler.sv
// Job sequencer for one mark_counter_assembly: accept job, reset assembly, run,
// merge results into a persistent best table. Optional watchdog: GOLOMB_JOB_TIMEOUT_EN.
module golomb_job_scheduler
  import golomb_pkg::*;
#(
  parameter  int MAXVALUE       = 22,
  parameter  int NUMPOSITIONS   = 5,
  parameter  int NUMRESULTS     = 10,
  parameter  int RESET_CYCLES   = 2,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int W              = (NUMPOSITIONS + 1) * MARK_W
) (
  input  logic                  FXCLK,
  input  logic                  RESET_IN,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [POS_W-1:0]      job_fvp,
  input  logic [W-1:0]          job_values,
  input  logic                  clear_best,
  output logic                  asm_reset,
  output logic [POS_W-1:0]      asm_fvp,
  output logic [W-1:0]          asm_firstvalues,
  input  logic                  asm_done,
  input  logic [CNT_W-1:0]      asm_num_results,
  input  logic [W*NUMRESULTS-1:0] asm_results,
  output logic                  busy,
  output logic [MARK_W-1:0]     best_len,
  output logic [CNT_W-1:0]      best_count,
  input  logic [CNT_W-1:0]      rd_idx,
  output logic [W-1:0]          rd_ruler,
  output logic [15:0]           jobs_done,
  output logic [7:0]            drop_count,
  output logic [7:0]            timeout_count
);

  sched_state_t          state_q, state_d;
  logic [7:0]            rst_cnt_q, rst_cnt_d;
  logic                  first_run_q, first_run_d;
  logic                  asm_reset_q, asm_reset_d;
  logic                  job_ready_q, job_ready_d;
  logic [POS_W-1:0]      asm_fvp_q, asm_fvp_d;
  logic [W-1:0]          asm_firstvalues_q, asm_firstvalues_d;
  logic [W*NUMRESULTS-1:0] results_q, results_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [15:0]           jobs_done_q, jobs_done_d;
  logic                  timeout_hit;
  logic                  merge_valid;
  logic                  merge_clear;
  logic [W-1:0]          merge_ruler;
`ifdef GOLOMB_JOB_TIMEOUT_EN
  logic [31:0]           wd_q, wd_d;
  logic [7:0]            timeout_count_q, timeout_count_d;
`endif

  always_comb begin
    state_d           = state_q;
    rst_cnt_d         = rst_cnt_q;
    first_run_d       = first_run_q;
    asm_fvp_d         = asm_fvp_q;
    asm_firstvalues_d = asm_firstvalues_q;
    results_d         = results_q;
    n_d               = n_q;
    idx_d             = idx_q;
    jobs_done_d       = jobs_done_q;
    timeout_hit       = 1'b0;
    merge_valid       = 1'b0;
    merge_clear       = 1'b0;
    merge_ruler       = '0;
`ifdef GOLOMB_JOB_TIMEOUT_EN
    wd_d              = wd_q;
    timeout_count_d   = timeout_count_q;
`endif

    // Entry 1 sits at the MSBs of the latched result vector.
    for (int k = 1; k <= NUMRESULTS; k++) begin
      if (idx_q == CNT_W'(k)) merge_ruler = results_q[W*(NUMRESULTS-k) +: W];
    end

    case (state_q)
      S_IDLE: begin
        if (clear_best) begin
          merge_clear = 1'b1;
        end else if (job_valid && job_ready_q) begin
          asm_fvp_d         = job_fvp;
          asm_firstvalues_d = job_values;
          rst_cnt_d         = '0;
          state_d           = S_ASM_RST;
        end
      end
      S_ASM_RST: begin
        if (rst_cnt_q == 8'(RESET_CYCLES - 1)) begin
          first_run_d = 1'b1;
          state_d     = S_RUN;
`ifdef GOLOMB_JOB_TIMEOUT_EN
          wd_d        = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        first_run_d = 1'b0;
        // A done left over from the previous job may still be high in the first cycle.
        if (!first_run_q && asm_done) begin
          results_d = asm_results;
          n_d       = (asm_num_results > CNT_W'(NUMRESULTS)) ? CNT_W'(NUMRESULTS)
                                                             : asm_num_results;
          idx_d     = CNT_W'(1);
          state_d   = (n_d == '0) ? S_FINISH : S_COLLECT;
        end
`ifdef GOLOMB_JOB_TIMEOUT_EN
        else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      S_COLLECT: begin
        merge_valid = 1'b1;
        if (idx_q == n_q) state_d = S_FINISH;
        else              idx_d   = idx_q + CNT_W'(1);
      end
      S_FINISH: begin
        jobs_done_d = jobs_done_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    asm_reset_d = (state_d == S_ASM_RST) || timeout_hit;
    job_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge FXCLK) begin
    if (!RESET_IN) begin
      state_q           <= S_IDLE;
      rst_cnt_q         <= '0;
      first_run_q       <= 1'b0;
      asm_reset_q       <= 1'b1;
      job_ready_q       <= 1'b0;
      asm_fvp_q         <= '0;
      asm_firstvalues_q <= '0;
      n_q               <= '0;
      idx_q             <= '0;
      jobs_done_q       <= '0;
`ifdef GOLOMB_JOB_TIMEOUT_EN
      wd_q              <= '0;
      timeout_count_q   <= '0;
`endif
    end else begin
      state_q           <= state_d;
      rst_cnt_q         <= rst_cnt_d;
      first_run_q       <= first_run_d;
      asm_reset_q       <= asm_reset_d;
      job_ready_q       <= job_ready_d;
      asm_fvp_q         <= asm_fvp_d;
      asm_firstvalues_q <= asm_firstvalues_d;
      n_q               <= n_d;
      idx_q             <= idx_d;
      jobs_done_q       <= jobs_done_d;
`ifdef GOLOMB_JOB_TIMEOUT_EN
      wd_q              <= wd_d;
      timeout_count_q   <= timeout_count_d;
`endif
    end
  end

  always_ff @(posedge FXCLK) begin
    results_q <= results_d;
  end

  golomb_result_merge #(
    .NUMPOSITIONS (NUMPOSITIONS),
    .NUMRESULTS   (NUMRESULTS)
  ) u_merge (
    .clk        (FXCLK),
    .rst_n      (RESET_IN),
    .clear      (merge_clear),
    .in_valid   (merge_valid),
    .in_ruler   (merge_ruler),
    .rd_idx     (rd_idx),
    .best_len   (best_len),
    .best_count (best_count),
    .drop_count (drop_count),
    .rd_ruler   (rd_ruler)
  );

  assign job_ready       = job_ready_q;
  assign asm_reset       = asm_reset_q;
  assign asm_fvp         = asm_fvp_q;
  assign asm_firstvalues = asm_firstvalues_q;
  assign busy            = (state_q != S_IDLE);
  assign jobs_done       = jobs_done_q;
`ifdef GOLOMB_JOB_TIMEOUT_EN
  assign timeout_count   = timeout_count_q;
`else
  assign timeout_count   = 8'd0;
`endif

endmodule

// File: tb/tb_golomb_job_scheduler.sv
// Directed bench for golomb_job_scheduler: the bench plays the assembly and
// compares against hand-computed values with immediate assertions.
module tb_golomb_job_scheduler;
  import golomb_pkg::*;

  localparam int NP = 5;
  localparam int NR = 10;
  localparam int W  = (NP + 1) * MARK_W;
  localparam int RW = W * NR;

  logic          FXCLK = 1'b0;
  logic          RESET_IN = 1'b0;
  logic          job_valid = 1'b0;
  logic [6:0]    job_fvp = '0;
  logic [W-1:0]  job_values = '0;
  logic          clear_best = 1'b0;
  logic          asm_done = 1'b0;
  logic [5:0]    asm_num_results = '0;
  logic [RW-1:0] asm_results = '0;
  logic [5:0]    rd_idx = '0;

  logic          job_ready, asm_reset, busy;
  logic [6:0]    asm_fvp;
  logic [W-1:0]  asm_firstvalues, rd_ruler;
  logic [8:0]    best_len;
  logic [5:0]    best_count;
  logic [15:0]   jobs_done;
  logic [7:0]    drop_count, timeout_count;

  int vectors = 0;
  int miscompares = 0;

  golomb_job_scheduler #(
    .MAXVALUE       (22),
    .NUMPOSITIONS   (NP),
    .NUMRESULTS     (NR),
    .RESET_CYCLES   (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .FXCLK           (FXCLK),
    .RESET_IN        (RESET_IN),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_fvp         (job_fvp),
    .job_values      (job_values),
    .clear_best      (clear_best),
    .asm_reset       (asm_reset),
    .asm_fvp         (asm_fvp),
    .asm_firstvalues (asm_firstvalues),
    .asm_done        (asm_done),
    .asm_num_results (asm_num_results),
    .asm_results     (asm_results),
    .busy            (busy),
    .best_len        (best_len),
    .best_count      (best_count),
    .rd_idx          (rd_idx),
    .rd_ruler        (rd_ruler),
    .jobs_done       (jobs_done),
    .drop_count      (drop_count),
    .timeout_count   (timeout_count)
  );

  always #5 FXCLK = ~FXCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk(input int m0, m1, m2, m3, m4, m5);
    return {9'(m0), 9'(m1), 9'(m2), 9'(m3), 9'(m4), 9'(m5)};
  endfunction

  task automatic tick();
    @(posedge FXCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int k, input logic [W-1:0] r);
    asm_results[RW - W*k +: W] = r;
  endtask

  task automatic start_job(input logic [6:0] f, input logic [W-1:0] v);
    int n = 0;
    while (!job_ready && n < 20) begin
      tick();
      n++;
    end
    check("start_ready", job_ready, 1);
    job_fvp    = f;
    job_values = v;
    job_valid  = 1'b1;
    tick();
    job_valid  = 1'b0;
  endtask

  task automatic finish_job();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("job_end", busy, 0);
    asm_done = 1'b0;
  endtask

  initial begin
    // ---- reset state
    tick(); tick(); tick();
    check("rst_busy",       busy, 0);
    check("rst_asm_reset",  asm_reset, 1);
    check("rst_job_ready",  job_ready, 0);
    check("rst_best_len",   best_len, 9'h1FF);
    check("rst_best_count", best_count, 0);
    check("rst_jobs_done",  jobs_done, 0);
    check("rst_drop",       drop_count, 0);
    check("rst_timeout",    timeout_count, 0);
    check("rst_asm_fvp",    asm_fvp, 0);
    check("rst_asm_fv",     asm_firstvalues, 0);
    check("rst_rd_ruler",   rd_ruler, 0);
    RESET_IN = 1'b1;
    tick();
    check("idle_ready",     job_ready, 1);
    check("idle_asm_reset", asm_reset, 0);

    // ---- job 1: two length-17 rulers, cycle by cycle
    job_fvp = 7'd1; job_values = '0; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check("j1_asm_reset_1", asm_reset, 1);
    check("j1_busy",        busy, 1);
    check("j1_ready_low",   job_ready, 0);
    check("j1_asm_fvp",     asm_fvp, 1);
    tick();
    check("j1_asm_reset_2", asm_reset, 1);
    tick();
    check("j1_run_no_rst",  asm_reset, 0);
    set_entry(1, mk(0, 1, 4, 10, 12, 17));
    set_entry(2, mk(0, 1, 8, 11, 13, 17));
    asm_num_results = 6'd2;
    asm_done = 1'b1;
    tick();
    check("j1_first_run_ignored", best_count, 0);
    check("j1_still_busy", busy, 1);
    tick();
    asm_done = 1'b0;
    check("j1_collect_start", best_count, 0);
    tick();
    check("j1_merge1_len",   best_len, 17);
    check("j1_merge1_count", best_count, 1);
    rd_idx = 6'd1;
    tick();
    check("j1_merge2_count", best_count, 2);
    check("j1_finish_ready", job_ready, 0);
    check("j1_finish_busy",  busy, 1);
    check("j1_rd_beyond",    rd_ruler, 0);
    tick();
    check("j1_ready",     job_ready, 1);
    check("j1_idle",      busy, 0);
    check("j1_jobs_done", jobs_done, 1);
    check("j1_best_len",  best_len, 17);
    check("j1_rd_ruler1", rd_ruler, mk(0, 1, 8, 11, 13, 17));

    // ---- job 2: one length-11 ruler replaces the table
    asm_results = '0;
    set_entry(1, mk(0, 0, 1, 4, 9, 11));
    asm_num_results = 6'd1;
    asm_done = 1'b1;
    start_job(7'd5, mk(0, 1, 0, 0, 0, 0));
    check("j2_asm_fvp", asm_fvp, 5);
    check("j2_asm_fv",  asm_firstvalues, mk(0, 1, 0, 0, 0, 0));
    finish_job();
    check("j2_best_len",   best_len, 11);
    check("j2_best_count", best_count, 1);
    check("j2_jobs_done",  jobs_done, 2);
    rd_idx = 6'd0;
    tick();
    check("j2_rd_ruler0", rd_ruler, mk(0, 0, 1, 4, 9, 11));

    // ---- stale asm_done with n=0: ignored for one RUN cycle, then FINISH
    asm_results = '0;
    asm_num_results = 6'd0;
    asm_done = 1'b1;
    start_job(7'd2, '0);
    tick();
    tick();
    tick();
    tick();
    check("stale_finish_busy", busy, 1);
    check("stale_finish_jobs", jobs_done, 2);
    tick();
    check("stale_idle",     busy, 0);
    check("stale_jobs",     jobs_done, 3);
    check("stale_best_len", best_len, 11);
    asm_done = 1'b0;

    // ---- clear_best together with job_valid: clear first, accept next cycle
    clear_best = 1'b1;
    job_fvp = 7'd3; job_values = '0; job_valid = 1'b1;
    tick();
    clear_best = 1'b0;
    check("clr_best_len",   best_len, 9'h1FF);
    check("clr_best_count", best_count, 0);
    check("clr_not_taken",  busy, 0);
    tick();
    job_valid = 1'b0;
    check("clr_job_taken",  busy, 1);

    // ---- job A: six length-13 rulers
    asm_results = '0;
    for (int k = 1; k <= 6; k++) set_entry(k, mk(0, 1, 2, 3, k + 3, 13));
    asm_num_results = 6'd6;
    asm_done = 1'b1;
    finish_job();
    check("ja_best_len",   best_len, 13);
    check("ja_best_count", best_count, 6);

    // ---- job B: six more length-13, plus zero and longer entries, count clamped
    asm_results = '0;
    for (int k = 1; k <= 6; k++) set_entry(k, mk(0, 2, 3, 4, k + 4, 13));
    set_entry(8, mk(0, 1, 3, 7, 12, 20));
    asm_num_results = 6'd15;
    asm_done = 1'b1;
    start_job(7'd4, '0);
    finish_job();
    check("jb_best_len",   best_len, 13);
    check("jb_best_count", best_count, 10);
    check("jb_drop",       drop_count, 2);
    check("jb_jobs_done",  jobs_done, 5);
    rd_idx = 6'd9;
    tick();
    check("jb_rd_last", rd_ruler, mk(0, 2, 3, 4, 8, 13));
    rd_idx = 6'd10;
    tick();
    check("jb_rd_oob",  rd_ruler, 0);

`ifdef GOLOMB_JOB_TIMEOUT_EN
    // ---- watchdog: no asm_done for TIMEOUT_CYCLES run cycles
    begin
      int n = 0;
      asm_done = 1'b0;
      start_job(7'd1, '0);
      tick();
      tick();
      while (busy && n < 200) begin
        tick();
        n++;
      end
      check("to_run_cycles", 64'(n), 50);
      check("to_asm_pulse",  asm_reset, 1);
      check("to_count",      timeout_count, 1);
      check("to_jobs_done",  jobs_done, 5);
      check("to_ready",      job_ready, 1);
      check("to_best_count", best_count, 10);
      tick();
      check("to_pulse_end",  asm_reset, 0);
    end
`else
    check("no_to_count", timeout_count, 0);
`endif

    // ---- reset asserted during COLLECT
    asm_results = '0;
    for (int k = 1; k <= 3; k++) set_entry(k, mk(0, 1, 3, 7, k + 7, 10));
    asm_num_results = 6'd3;
    asm_done = 1'b1;
    start_job(7'd1, '0);
    tick();
    tick();
    tick();
    tick();
    asm_done = 1'b0;
    check("mr_in_collect", busy, 1);
    RESET_IN = 1'b0;
    tick();
    check("mr_busy",       busy, 0);
    check("mr_best_count", best_count, 0);
    check("mr_best_len",   best_len, 9'h1FF);
    check("mr_asm_reset",  asm_reset, 1);
    check("mr_ready",      job_ready, 0);
    check("mr_jobs_done",  jobs_done, 0);
    RESET_IN = 1'b1;
    tick();
    check("mr_ready_after", job_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
